// File: rtl/cordic_rr_scheduler_pkg.sv
// Shared types for the cordic round-robin scheduler.
//   state_e   : scheduler FSM states
//   timeout_w : width of a counter that must hold the value TIMEOUT
package cordic_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        BUSY,
        RESPOND
    } state_e;

    function automatic int unsigned timeout_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Requester-side bus of the cordic scheduler.
//   req_valid/req_ready : per-requester handshake (ready is a one-hot accept pulse)
//   req_angle/x/y       : packed operands, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   req_mode            : per-requester core mode (0 rotate, 1 vector)
//   rsp_valid           : one-hot, one-cycle response pulse to the owner
//   rsp_error           : qualifies rsp_valid, 1 = watchdog abort (data forced to 0)
//   rsp_angle/x/y       : shared result bus, valid with rsp_valid
interface cordic_rr_scheduler_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BIT_WIDTH = 16
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_angle;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_x;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_y;
    logic [NUM_REQ-1:0]           req_mode;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic                         rsp_error;
    logic [BIT_WIDTH-1:0]         rsp_angle;
    logic [BIT_WIDTH-1:0]         rsp_x;
    logic [BIT_WIDTH-1:0]         rsp_y;

    // Requesters drive operands and consume responses.
    modport master (
        output req_valid, req_angle, req_x, req_y, req_mode,
        input  req_ready, rsp_valid, rsp_error, rsp_angle, rsp_x, rsp_y
    );

    // The scheduler accepts requests and produces responses.
    modport slave (
        input  req_valid, req_angle, req_x, req_y, req_mode,
        output req_ready, rsp_valid, rsp_error, rsp_angle, rsp_x, rsp_y
    );
endinterface

// File: rtl/cordic_rr_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot winner (first set bit from ptr upward, wrapping)
//   id    : binary index of the winner
//   any   : at least one request present
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // Walk requesters starting at ptr; first hit wins.
    always_comb begin : pick
        int unsigned idx;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[ID_W'(idx)]) begin
                any                = 1'b1;
                grant[ID_W'(idx)]  = 1'b1;
                id                 = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one cordic core among NUM_REQ requesters.
//   clk, reset_n       : clock, asynchronous active-low reset
//   bus (slave)        : requester handshake, operands and responses
//   core_start         : one-cycle start pulse to the core
//   core_angle/x/y/mode: operands latched at grant, stable until the next grant
//   core_ready         : core idle; its fall acknowledges core_start
//   core_done          : core result valid, core_out_* carry the result
//   busy               : scheduler not in IDLE
module cordic_rr_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int unsigned BIT_WIDTH       = 16,
    parameter int unsigned LOG_2_BIT_WIDTH = 4,
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ID_W            = 2,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cordic_rr_scheduler_if.slave bus,
    output logic                 core_start,
    output logic [BIT_WIDTH-1:0] core_angle,
    output logic [BIT_WIDTH-1:0] core_x,
    output logic [BIT_WIDTH-1:0] core_y,
    output logic                 core_mode,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic [BIT_WIDTH-1:0] core_out_angle,
    input  logic [BIT_WIDTH-1:0] core_out_x,
    input  logic [BIT_WIDTH-1:0] core_out_y,
    output logic                 busy
);

    localparam int unsigned TW = timeout_w(TIMEOUT);

    // Elaboration-time parameter sanity.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end
    if (LOG_2_BIT_WIDTH != $clog2(BIT_WIDTH)) begin : g_bad_log2
        $error("LOG_2_BIT_WIDTH must equal clog2(BIT_WIDTH)");
    end
    if (TIMEOUT < BIT_WIDTH + 4) begin : g_bad_timeout
        $error("TIMEOUT must be at least BIT_WIDTH+4");
    end

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      owner_q, owner_d;
    logic [TW-1:0]        wd_q, wd_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_error_q, rsp_error_d;
    logic [BIT_WIDTH-1:0] rsp_angle_q, rsp_angle_d;
    logic [BIT_WIDTH-1:0] rsp_x_q, rsp_x_d;
    logic [BIT_WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic                 core_start_q, core_start_d;
    logic [BIT_WIDTH-1:0] core_angle_q, core_angle_d;
    logic [BIT_WIDTH-1:0] core_x_q, core_x_d;
    logic [BIT_WIDTH-1:0] core_y_q, core_y_d;
    logic                 core_mode_q, core_mode_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        wd_d         = wd_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_error_d  = rsp_error_q;
        rsp_angle_d  = rsp_angle_q;
        rsp_x_d      = rsp_x_q;
        rsp_y_d      = rsp_y_q;
        core_start_d = 1'b0;
        core_angle_d = core_angle_q;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_mode_d  = core_mode_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any && core_ready) begin
                    req_ready_d = pick_grant;
                    owner_d     = pick_id;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (pick_grant[i]) begin
                            core_angle_d = bus.req_angle[i*BIT_WIDTH +: BIT_WIDTH];
                            core_x_d     = bus.req_x[i*BIT_WIDTH +: BIT_WIDTH];
                            core_y_d     = bus.req_y[i*BIT_WIDTH +: BIT_WIDTH];
                            core_mode_d  = bus.req_mode[i];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_start_d = 1'b1;
                wd_d         = '0;
                state_d      = WAIT_ACK;
            end
            WAIT_ACK, BUSY: begin
                // A done seen before the core dropped ready belongs to an older op.
                if (state_q == BUSY && core_done) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_error_d = 1'b0;
                    rsp_angle_d = core_out_angle;
                    rsp_x_d     = core_out_x;
                    rsp_y_d     = core_out_y;
                    state_d     = RESPOND;
                end else if (wd_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_error_d = 1'b1;
                    rsp_angle_d = '0;
                    rsp_x_d     = '0;
                    rsp_y_d     = '0;
                    state_d     = RESPOND;
                end else begin
                    wd_d = wd_q + TW'(1);
                    if (state_q == WAIT_ACK && !core_ready) begin
                        state_d = BUSY;
                    end
                end
            end
            RESPOND: begin
                rsp_error_d = 1'b0;
                rr_ptr_d    = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            wd_q         <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_error_q  <= 1'b0;
            rsp_angle_q  <= '0;
            rsp_x_q      <= '0;
            rsp_y_q      <= '0;
            core_start_q <= 1'b0;
            core_angle_q <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_mode_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            wd_q         <= wd_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_angle_q  <= rsp_angle_d;
            rsp_x_q      <= rsp_x_d;
            rsp_y_q      <= rsp_y_d;
            core_start_q <= core_start_d;
            core_angle_q <= core_angle_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_mode_q  <= core_mode_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_angle = rsp_angle_q;
    assign bus.rsp_x     = rsp_x_q;
    assign bus.rsp_y     = rsp_y_q;
    assign core_start    = core_start_q;
    assign core_angle    = core_angle_q;
    assign core_x        = core_x_q;
    assign core_y        = core_y_q;
    assign core_mode     = core_mode_q;
    assign busy          = busy_q;

endmodule
